// File: rtl/ir_code_queue.sv
`default_nettype none
// ============================================================================
// Module   : ir_code_queue
// Desc     : IR frame capture, cmd/~cmd check, optional repeat filter
//            (IR_REPEAT_FILTER_EN) and a CPU-side code FIFO with level irq.
// Revision : 1.0 - initial release
// ============================================================================
module ir_code_queue #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_TICKS = 5400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [31:0] rx_data,
  output logic        rx_read,
  input  logic        s_cs_n,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_FILTER = 3'd3;
  localparam logic [2:0] ST_PUSH   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          rx_ready_q;
  logic          rx_read_q;
  logic [31:0]   frame_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [15:0]   drop_q;
  logic          irq_en_q;
  logic          irq_q;
  logic [31:0]   rdata_q;

  logic rd_acc, wr_acc, ctrl_wr, flush, clr;
  logic empty, full, pop, push, ovf_evt, drop_evt;
  logic frame_ok, is_repeat;

  assign rd_acc   = ~s_cs_n & s_read;
  assign wr_acc   = ~s_cs_n & s_write;
  assign ctrl_wr  = wr_acc & (s_address == 2'd2);
  assign flush    = ctrl_wr & s_writedata[1];
  assign clr      = ctrl_wr & s_writedata[2];
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign frame_ok = (frame_q[31:24] == ~frame_q[23:16]);

  // Flush overrides everything queued this cycle, including a pending push.
  assign pop      = rd_acc & (s_address == 2'd0) & ~empty & ~flush;
  assign push     = (state_q == ST_PUSH) & (~full | pop) & ~flush;
  assign ovf_evt  = (state_q == ST_PUSH) & full & ~pop & ~flush;
  assign drop_evt = ((state_q == ST_CHECK) & ~frame_ok) | ovf_evt;

  wire unused_wdata = ^s_writedata[31:3];

`ifdef IR_REPEAT_FILTER_EN
  logic [23:0] timer_q;
  logic [31:0] last_q;

  assign is_repeat = (frame_q == last_q) && (timer_q != 24'd0);

  // Every valid frame restarts the hold window, whether it is kept or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      last_q  <= '0;
    end else if (state_q == ST_FILTER) begin
      timer_q <= 24'(REPEAT_TICKS);
      if (!is_repeat) last_q <= frame_q;
    end else if (timer_q != 24'd0) begin
      timer_q <= timer_q - 24'd1;
    end
  end
`else
  assign is_repeat = 1'b0;
  wire [23:0] unused_ticks = 24'(REPEAT_TICKS);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_ready && !rx_ready_q) state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_CHECK;
      ST_CHECK:  state_d = frame_ok ? ST_FILTER : ST_IDLE;
      ST_FILTER: state_d = is_repeat ? ST_IDLE : ST_PUSH;
      ST_PUSH:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      rx_read_q  <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready;
      rx_read_q  <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) frame_q <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= frame_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else begin
        if (ovf_evt) ovf_q <= 1'b1;
        if (drop_evt && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
      if (ctrl_wr) irq_en_q <= s_writedata[0];
      irq_q <= irq_en_q & ~empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      case (s_address)
        2'd0:    rdata_q <= empty ? 32'd0 : mem_q[rd_ptr_q];
        2'd1:    rdata_q <= {drop_q, 8'(count_q), 5'd0, ovf_q, full, empty};
        2'd2:    rdata_q <= {31'd0, irq_en_q};
        default: rdata_q <= 32'd0;
      endcase
    end
  end

  assign rx_read    = rx_read_q;
  assign irq        = irq_q;
  assign s_readdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_code_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_code_queue
// Desc     : directed and randomized checks of ir_code_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_code_queue;

  localparam int DEPTH = 8;
  localparam int TICKS = 200;
`ifdef IR_REPEAT_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        rx_read;
  logic        s_cs_n;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;

  ir_code_queue #(.DEPTH(DEPTH), .REPEAT_TICKS(TICKS)) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data), .rx_read(rx_read),
    .s_cs_n(s_cs_n), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: ordered list of pending codes plus counters.
  logic [31:0] mq[$];
  int          m_drop;
  bit          m_ovf;
  bit          m_have_last;
  logic [31:0] m_last;
  int unsigned m_valid_stamp;
  logic [31:0] ov_codes [DEPTH+1];

  function automatic logic [31:0] exp_status();
    int n;
    n = mq.size();
    return {16'(m_drop > 65535 ? 65535 : m_drop), 8'(n), 5'd0, m_ovf, (n == DEPTH), (n == 0)};
  endfunction

  task automatic model_frame(input logic [31:0] d, input int unsigned stamp);
    bit rpt;
    if (d[31:24] != ~d[23:16]) begin
      m_drop++;
      return;
    end
    rpt = FILTER_ON && m_have_last && (d == m_last) && ((stamp - m_valid_stamp) <= TICKS);
    m_valid_stamp = stamp;
    if (rpt) return;
    m_last = d;
    m_have_last = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(d);
    else begin
      m_ovf = 1'b1;
      m_drop++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_drop = 0;
    m_ovf = 1'b0;
    m_have_last = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_cs_n = 1'b1; s_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_cs_n = 1'b1; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic send_frame(input logic [31:0] d, output int unsigned stamp);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    rx_ready = 1'b1; rx_data = d; stamp = cyc;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (rx_read) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL ack_timeout: got no rx_read want pulse (frame %h)", d); end
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_cmp++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL rst_rx_read: got %b want 0", rx_read); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_cmp++; if (s_readdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", s_readdata); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_status: got %h want 00000001", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", d); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL empty_data: got %h want 0", d); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL empty_no_pop: got %h want 00000001", d); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reg3: got %h want 0", d); end
  endtask

  task automatic test_valid_frame();
    logic [31:0] d;
    do_reset();
    bus_write(2'd2, 32'h1);
    @(negedge clk); rx_ready = 1'b1; rx_data = 32'hEF10_00FF;
    @(posedge clk); #1;
    n_cmp++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL ack_n0: got %b want 0", rx_read); end
    @(posedge clk); #1;
    n_cmp++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL ack_n1: got %b want 1", rx_read); end
    @(negedge clk); rx_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL ack_n2: got %b want 0", rx_read); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_n4: got %b want 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_n5: got %b want 1", irq); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL valid_status: got %h want 00000100", d); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'hEF10_00FF) begin n_fail++; $display("FAIL valid_data: got %h want ef1000ff", d); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop: got %b want 0", irq); end
  endtask

  task automatic test_invalid_frame();
    logic [31:0] d;
    int unsigned s;
    do_reset();
    bus_write(2'd2, 32'h1);
    send_frame(32'h1234_00FF, s);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL invalid_status: got %h want 00010001", d); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL invalid_irq: got %b want 0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  c;
    int unsigned s;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      c = 8'(i * 17 + 3);
      ov_codes[i] = {~c, c, 16'hA500 | 16'(i)};
      send_frame(ov_codes[i], s);
    end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0001_0806) begin n_fail++; $display("FAIL ovf_status: got %h want 00010806", d); end
    bus_write(2'd2, 32'h4);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000802", d); end
  endtask

  // Relies on test_overflow leaving DEPTH entries queued.
  task automatic test_push_pop_full();
    logic [31:0] d;
    logic [31:0] x;
    x = {8'h3C, 8'hC3, 16'h7777};
    @(negedge clk); rx_ready = 1'b1; rx_data = x;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL pp_ack: got %b want 1", rx_read); end
    rx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = 2'd0;
    @(negedge clk);
    s_cs_n = 1'b1; s_read = 1'b0;
    d = s_readdata;
    n_cmp++; if (d !== ov_codes[0]) begin n_fail++; $display("FAIL pp_head: got %h want %h", d, ov_codes[0]); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL pp_status: got %h want 00000802", d); end
    for (int i = 1; i < DEPTH; i++) begin
      bus_read(2'd0, d);
      n_cmp++; if (d !== ov_codes[i]) begin n_fail++; $display("FAIL pp_drain%0d: got %h want %h", i, d, ov_codes[i]); end
    end
    bus_read(2'd0, d);
    n_cmp++; if (d !== x) begin n_fail++; $display("FAIL pp_tail: got %h want %h", d, x); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL pp_empty: got %h want 00000001", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int unsigned s;
    bus_write(2'd2, 32'h1);
    send_frame(32'h6699_0001, s);
    send_frame(32'h55AA_0002, s);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL flush_pre_irq: got %b want 1", irq); end
    // Third frame's PUSH cycle coincides with the flush write.
    @(negedge clk); rx_ready = 1'b1; rx_data = 32'h44BB_0003;
    @(negedge clk);
    @(negedge clk); rx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = 2'd2; s_writedata = 32'h3;
    @(negedge clk);
    s_cs_n = 1'b1; s_write = 1'b0;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_status: got %h want 00000001", d); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL flush_irq: got %b want 0", irq); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL flush_ctrl: got %h want 00000001", d); end
  endtask

  task automatic test_repeat();
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] want;
    int unsigned s;
    a = 32'h7F80_1234;
    do_reset();
    send_frame(a, s);
    repeat (50) @(negedge clk);
    send_frame(a, s);
    bus_read(2'd1, d);
    want = FILTER_ON ? 32'h0000_0100 : 32'h0000_0200;
    n_cmp++; if (d !== want) begin n_fail++; $display("FAIL rpt_short: got %h want %h", d, want); end
    do_reset();
    send_frame(a, s);
    repeat (TICKS + 10) @(negedge clk);
    send_frame(a, s);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0200) begin n_fail++; $display("FAIL rpt_long: got %h want 00000200", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic [31:0] y;
    int unsigned s;
    y = 32'hB04F_0A0B;
    do_reset();
    bus_write(2'd2, 32'h1);
    @(negedge clk); rx_ready = 1'b1; rx_data = y;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL rst_latch_ack: got %b want 0", rx_read); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0; rx_ready = 1'b0;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_latch_status: got %h want 00000001", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_latch_ctrl: got %h want 0", d); end
    @(negedge clk); rx_ready = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    n_cmp++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL pre_rst_ack: got %b want 1", rx_read); end
    reset = 1'b1;
    #1;
    n_cmp++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL async_ack_clear: got %b want 0", rx_read); end
    @(negedge clk);
    reset = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(y, s);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL post_rst_status: got %h want 00000100", d); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== y) begin n_fail++; $display("FAIL post_rst_data: got %h want %h", d, y); end
  endtask

  task automatic test_random();
    logic [31:0] d, rd, want;
    logic [7:0]  cmd, inv, mask;
    logic [7:0]  pool [4];
    int unsigned s;
    pool[0] = 8'h10; pool[1] = 8'h42; pool[2] = 8'h9C; pool[3] = 8'hE7;
    do_reset();
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 80; i++) begin
      cmd = pool[$urandom_range(0, 3)];
      inv = ~cmd;
      if ($urandom_range(0, 99) < 20) begin
        mask = 8'(1 << $urandom_range(0, 7));
        inv = inv ^ mask;
      end
      d = {inv, cmd, 16'h55AA};
      send_frame(d, s);
      model_frame(d, s);
      n_cmp++; if (irq !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_irq%0d: got %b want %b", i, irq, (mq.size() != 0)); end
      if ($urandom_range(0, 99) < 45) begin
        bus_read(2'd0, rd);
        want = (mq.size() != 0) ? mq.pop_front() : 32'd0;
        n_cmp++; if (rd !== want) begin n_fail++; $display("FAIL rnd_data%0d: got %h want %h", i, rd, want); end
      end
      if (i % 8 == 7) begin
        bus_read(2'd1, rd);
        want = exp_status();
        n_cmp++; if (rd !== want) begin n_fail++; $display("FAIL rnd_status%0d: got %h want %h", i, rd, want); end
      end
    end
    while (mq.size() != 0) begin
      bus_read(2'd0, rd);
      want = mq.pop_front();
      n_cmp++; if (rd !== want) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", rd, want); end
    end
    bus_read(2'd1, rd);
    want = exp_status();
    n_cmp++; if (rd !== want) begin n_fail++; $display("FAIL rnd_final_status: got %h want %h", rd, want); end
  endtask

  initial begin
    reset = 1'b1; rx_ready = 1'b0; rx_data = '0;
    s_cs_n = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    test_reset();
    test_valid_frame();
    test_invalid_frame();
    test_overflow();
    test_push_pop_full();
    test_flush();
    test_repeat();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
